// File: rtl/pbit_comparator_pkg.sv
// Shared constants and the sigmoid table generator for the p-bit comparator.
`include "header.vh"

package pbit_comparator_pkg;

   localparam int PBIT_BETA_W = 3;

   // Hard (piecewise-linear) sigmoid: maps the full signed input range onto
   // 0 .. 2^rw-1. idx is the raw two's-complement bit pattern of the input.
   function automatic longint unsigned pbit_sig_entry(input int idx, input int iw, input int rw);
      longint unsigned off;
      longint unsigned imax;
      longint unsigned omax;
      off  = longint'(idx) ^ (64'd1 << (iw - 1));
      imax = (64'd1 << iw) - 64'd1;
      omax = (64'd1 << rw) - 64'd1;
      return (off * omax) / imax;
   endfunction

endpackage

// File: rtl/header.vh
// Shared widths and saturation limits for the p-bit datapath.
`ifndef PBIT_HEADER_VH
`define PBIT_HEADER_VH

`define LFSR_TO_COMPARATOR 8

// Signed limits of a w-bit two's-complement field, as 64-bit signed constants.
`define PBIT_SAT_MAX(w) ((64'sd1 <<< ((w) - 1)) - 64'sd1)
`define PBIT_SAT_MIN(w) (-(64'sd1 <<< ((w) - 1)))

`endif

// File: rtl/pbit_sigmoid_lut.sv
// Combinational sigmoid ROM, 2^IW entries of RW bits, indexed by the scaled field.
module pbit_sigmoid_lut
   import pbit_comparator_pkg::*;
#(
   parameter int IW = 8,
   parameter int RW = 8
) (
   input  logic [IW-1:0] idx,
   output logic [RW-1:0] thr
);

   logic [RW-1:0] w_rom [2**IW];

   for (genvar i = 0; i < 2**IW; i++) begin : g_rom
      assign w_rom[i] = RW'(pbit_sig_entry(i, IW, RW));
   end

   assign thr = w_rom[idx];

endmodule

// File: rtl/pbit_comparator.sv
// Stochastic p-bit: scale field by 2^beta, sigmoid, compare against a random word.
// Optional window statistics on accepted spins under macro PBIT_STATS_EN.
`include "header.vh"

module pbit_comparator
   import pbit_comparator_pkg::*;
#(
   parameter int RW    = `LFSR_TO_COMPARATOR,
   parameter int IW    = 8,
   parameter int NSAMP = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [RW-1:0]              rnd,
   input  logic                       field_valid,
   input  logic signed [IW-1:0]       field,
   input  logic [PBIT_BETA_W-1:0]     beta,
   output logic                       field_ready,
   output logic                       spin_valid,
   output logic                       spin,
   input  logic                       spin_ready,
   output logic                       avg_valid,
   output logic [$clog2(NSAMP):0]     avg
);

   // Extra headroom covers the largest shift (7) without wrap.
   localparam int WW = IW + 8;
   localparam logic signed [WW-1:0] SAT_MAX = WW'(`PBIT_SAT_MAX(IW));
   localparam logic signed [WW-1:0] SAT_MIN = WW'(`PBIT_SAT_MIN(IW));
   localparam logic [RW-1:0]        THR_MAX = '1;

   logic [WW-1:0]        w_ext;
   logic signed [WW-1:0] w_wide;
   logic [IW-1:0]        w_scaled;
   logic [RW-1:0]        w_thr;
   logic                 w_s1_adv;
   logic                 w_s2_adv;

   logic                 r_s1_valid;
   logic                 r_s2_valid;
   logic [RW-1:0]        r_thr;
   logic                 r_spin;

   assign w_ext  = {{8{field[IW-1]}}, field};
   assign w_wide = w_ext << beta;

   always_comb begin
      w_scaled = w_wide[IW-1:0];
      if (w_wide > SAT_MAX)
         w_scaled = SAT_MAX[IW-1:0];
      else if (w_wide < SAT_MIN)
         w_scaled = SAT_MIN[IW-1:0];
   end

   pbit_sigmoid_lut #(.IW(IW), .RW(RW)) u_lut (
      .idx (w_scaled),
      .thr (w_thr)
   );

   assign w_s2_adv    = !r_s2_valid || spin_ready;
   assign w_s1_adv    = !r_s1_valid || w_s2_adv;
   assign field_ready = w_s1_adv;
   assign spin_valid  = r_s2_valid;
   assign spin        = r_spin;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_thr      <= '0;
         r_spin     <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= field_valid;
            if (field_valid)
               r_thr <= w_thr;
         end
         // Full-scale threshold forces +1 so the top of the sigmoid is certain.
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid)
               r_spin <= (r_thr == THR_MAX) || (rnd < r_thr);
         end
      end
   end

`ifdef PBIT_STATS_EN
   localparam int CW = $clog2(NSAMP);
   localparam int AW = CW + 1;

   logic          w_hs;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_sum;
   logic [AW-1:0] r_avg;
   logic          r_avg_valid;

   assign w_hs = r_s2_valid && spin_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_sum       <= '0;
         r_avg       <= '0;
         r_avg_valid <= 1'b0;
      end else begin
         r_avg_valid <= 1'b0;
         if (w_hs) begin
            if (r_cnt == CW'(NSAMP - 1)) begin
               r_avg       <= r_sum + AW'(r_spin);
               r_avg_valid <= 1'b1;
               r_cnt       <= '0;
               r_sum       <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
               r_sum <= r_sum + AW'(r_spin);
            end
         end
      end
   end

   assign avg       = r_avg;
   assign avg_valid = r_avg_valid;
`else
   assign avg       = '0;
   assign avg_valid = 1'b0;
`endif

endmodule
